// File: rtl/shift_ex_stage.sv
// Shift execute stage: SHL/SHR/SAR on a byte/word/dword field with x86-style flags.
// One-entry output register with valid/ready handshake and an accepted-op counter.
module shift_ex_stage #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [1:0]       in_opSize,
  input  logic [31:0]      in_data,
  input  logic [7:0]       in_count,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_cf,
  output logic             out_zf,
  output logic             out_sf,
  output logic             out_of,
  output logic             out_flags_we,
  output logic [CNT_W-1:0] op_cnt
);

  localparam logic [1:0] OP_SHR = 2'b01;
  localparam logic [1:0] OP_SAR = 2'b10;

  logic        accept;
  logic [4:0]  cnt;
  logic [5:0]  cnt6;
  logic [5:0]  n;
  logic [4:0]  msb_idx;
  logic [31:0] mask;
  logic [31:0] field;
  logic [31:0] ext;
  logic [31:0] res_f;
  logic [31:0] res;
  logic        sign;
  logic        res_msb;
  logic        cf;
  logic        zf;
  logic        of;

  assign in_ready = !out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  always_comb begin
    cnt  = in_count[4:0];
    cnt6 = {1'b0, cnt};
    case (in_opSize)
      2'b00:   begin n = 6'd8;  mask = 32'h0000_00FF; end
      2'b01:   begin n = 6'd16; mask = 32'h0000_FFFF; end
      default: begin n = 6'd32; mask = 32'hFFFF_FFFF; end
    endcase
    msb_idx = 5'(n - 6'd1);
    field   = in_data & mask;
    sign    = in_data[msb_idx];
    // Sign-extend the field across all 32 bits so >>> fills with the field's sign.
    ext     = field | (sign ? ~mask : 32'h0);
    case (in_op)
      OP_SHR:  res_f = field >> cnt;
      OP_SAR:  res_f = $unsigned($signed(ext) >>> cnt);
      default: res_f = field << cnt;
    endcase
    res     = (in_data & ~mask) | (res_f & mask);
    res_msb = res[msb_idx];
    zf      = ((res & mask) == 32'h0);

    if (cnt6 > n)
      cf = (in_op == OP_SAR) ? sign : 1'b0;
    else if (in_op == OP_SHR || in_op == OP_SAR)
      cf = in_data[5'(cnt6 - 6'd1)];
    else
      cf = in_data[5'(n - cnt6)];

    if (cnt == 5'd1) begin
      case (in_op)
        OP_SHR:  of = sign;
        OP_SAR:  of = 1'b0;
        default: of = res_msb ^ cf;
      endcase
    end else begin
      of = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_data     <= 32'h0;
      out_cf       <= 1'b0;
      out_zf       <= 1'b0;
      out_sf       <= 1'b0;
      out_of       <= 1'b0;
      out_flags_we <= 1'b0;
      op_cnt       <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        op_cnt    <= op_cnt + CNT_W'(1);
        if (cnt == 5'd0) begin
          out_data     <= in_data;
          out_cf       <= 1'b0;
          out_zf       <= 1'b0;
          out_sf       <= 1'b0;
          out_of       <= 1'b0;
          out_flags_we <= 1'b0;
        end else begin
          out_data     <= res;
          out_cf       <= cf;
          out_zf       <= zf;
          out_sf       <= res_msb;
          out_of       <= of;
          out_flags_we <= 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_shift_ex_stage.sv
// Scoreboard bench for shift_ex_stage: directed vectors, backpressure, async reset, counter wrap.
module tb_shift_ex_stage;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_op;
  logic [1:0]       in_opSize;
  logic [31:0]      in_data;
  logic [7:0]       in_count;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic             out_cf;
  logic             out_zf;
  logic             out_sf;
  logic             out_of;
  logic             out_flags_we;
  logic [CNT_W-1:0] op_cnt;

  int errors = 0;
  int checks = 0;

  // expected {data, cf, zf, sf, of, flags_we}
  logic [36:0] exp_q[$];

  typedef struct packed {
    logic [1:0]  op;
    logic [1:0]  sz;
    logic [31:0] d;
    logic [7:0]  c;
    logic [31:0] ed;
    logic [4:0]  ef;
  } vec_t;

  vec_t vecs[12];

  shift_ex_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_opSize(in_opSize), .in_data(in_data), .in_count(in_count),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_cf(out_cf), .out_zf(out_zf), .out_sf(out_sf), .out_of(out_of),
    .out_flags_we(out_flags_we), .op_cnt(op_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [36:0] act, input logic [36:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Monitor: a result leaves the stage at the next edge whenever out_valid & out_ready.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got data=0x%08h with no pending expectation", out_data);
      end else begin
        logic [36:0] e;
        logic [36:0] a;
        e = exp_q.pop_front();
        a = {out_data, out_cf, out_zf, out_sf, out_of, out_flags_we};
        if (a !== e) begin
          errors++;
          $display("FAIL result: got data=0x%08h flags=%05b expected data=0x%08h flags=%05b",
                   a[36:5], a[4:0], e[36:5], e[4:0]);
        end
      end
    end
  end

  // Presents an op and leaves in_valid high; returns just after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [1:0] sz, input logic [31:0] d,
                      input logic [7:0] c, input logic [31:0] ed, input logic [4:0] ef);
    int n;
    n = 0;
    in_valid  = 1'b1;
    in_op     = op;
    in_opSize = sz;
    in_data   = d;
    in_count  = c;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (!in_ready) begin
      errors++;
      $display("FAIL send_timeout: in_ready=%0b after %0d cycles, required 1", in_ready, n);
    end else begin
      exp_q.push_back({ed, ef});
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("drain_pending", 37'(exp_q.size()), 37'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    exp_q.delete();
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0]  = '{2'b10, 2'b10, 32'h8000_0010, 8'd4,    32'hF800_0001, 5'b00101};
    vecs[1]  = '{2'b00, 2'b00, 32'h1234_5681, 8'd1,    32'h1234_5602, 5'b10011};
    vecs[2]  = '{2'b01, 2'b01, 32'h0000_8001, 8'h21,   32'h0000_4000, 5'b10011};
    vecs[3]  = '{2'b01, 2'b01, 32'h0000_8001, 8'h20,   32'h0000_8001, 5'b00000};
    vecs[4]  = '{2'b00, 2'b00, 32'hAABB_CC0F, 8'd9,    32'hAABB_CC00, 5'b01001};
    vecs[5]  = '{2'b10, 2'b00, 32'h0000_0080, 8'd8,    32'h0000_00FF, 5'b10101};
    vecs[6]  = '{2'b10, 2'b01, 32'h1234_8000, 8'd20,   32'h1234_FFFF, 5'b10101};
    vecs[7]  = '{2'b00, 2'b01, 32'h0000_4001, 8'd16,   32'h0000_0000, 5'b11001};
    vecs[8]  = '{2'b11, 2'b10, 32'h4000_0001, 8'd1,    32'h8000_0002, 5'b00111};
    vecs[9]  = '{2'b01, 2'b11, 32'h8000_0000, 8'd31,   32'h0000_0001, 5'b00001};
    vecs[10] = '{2'b10, 2'b10, 32'h8000_0000, 8'd1,    32'hC000_0000, 5'b00101};
    vecs[11] = '{2'b01, 2'b00, 32'h0000_00FF, 8'd1,    32'h0000_007F, 5'b10011};

    rst = 1'b1;
    in_valid = 1'b0; in_op = 2'b00; in_opSize = 2'b00; in_data = 32'h0; in_count = 8'h0;
    out_ready = 1'b1;
    #12;
    chk("reset_out_valid", 37'(out_valid), 37'd0);
    chk("reset_out_data", 37'(out_data), 37'd0);
    chk("reset_flags", 37'({out_cf, out_zf, out_sf, out_of, out_flags_we}), 37'd0);
    chk("reset_op_cnt", 37'(op_cnt), 37'd0);
    chk("reset_in_ready", 37'(in_ready), 37'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed vectors, streamed back to back.
    for (int i = 0; i < 12; i++)
      send(vecs[i].op, vecs[i].sz, vecs[i].d, vecs[i].c, vecs[i].ed, vecs[i].ef);
    drain();
    chk("op_cnt_after_vectors", 37'(op_cnt), 37'd12);

    // Backpressure: first result must hold while the second op waits upstream.
    reset_dut();
    out_ready = 1'b0;
    send(2'b10, 2'b10, 32'h8000_0010, 8'd4, 32'hF800_0001, 5'b00101);
    fork
      send(2'b00, 2'b00, 32'h1234_5681, 8'd1, 32'h1234_5602, 5'b10011);
      begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          chk("hold_valid", 37'(out_valid), 37'd1);
          chk("hold_data_flags", {out_data, out_cf, out_zf, out_sf, out_of, out_flags_we},
              {32'hF800_0001, 5'b00101});
          chk("hold_in_ready", 37'(in_ready), 37'd0);
          chk("hold_op_cnt", 37'(op_cnt), 37'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    chk("bp_op_cnt", 37'(op_cnt), 37'd2);
    chk("bp_no_bubble", 37'(out_valid), 37'd1);
    drain();

    // Async reset between edges while a result is held.
    out_ready = 1'b0;
    send(2'b00, 2'b10, 32'h0000_0001, 8'd1, 32'h0000_0002, 5'b00011);
    #2;
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("async_rst_valid", 37'(out_valid), 37'd0);
    chk("async_rst_op_cnt", 37'(op_cnt), 37'd0);
    chk("async_rst_data", 37'(out_data), 37'd0);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_edge_no_accept_cnt", 37'(op_cnt), 37'd0);
    chk("rst_edge_no_accept_valid", 37'(out_valid), 37'd0);
    in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Counter wrap after 2^CNT_W accepts; count 0 passes data through with no flags.
    for (int i = 0; i < (1 << CNT_W); i++) begin
      send(2'b00, 2'b10, 32'(i * 3 + 1), 8'h00, 32'(i * 3 + 1), 5'b00000);
      if (i == (1 << CNT_W) - 2)
        chk("op_cnt_max", 37'(op_cnt), 37'((1 << CNT_W) - 1));
    end
    chk("op_cnt_wrap", 37'(op_cnt), 37'd0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
